// File: rtl/instr_encoder_loader.sv
// rtl/instr_encoder_loader.sv - micro-op to RV32I encoder with FIFO-buffered instruction memory loader
module instr_encoder_loader #(
  parameter int ADDR_W     = 12,
  parameter int BASE_ADDR  = 0,
  parameter int MAX_WORDS  = 256,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_opcode,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [4:0]        in_rd,
  input  logic [31:0]       in_imm,
  input  logic              in_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  input  logic              imem_ready,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] word_count,
  output logic              err,
  output logic [1:0]        err_code
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam logic [ADDR_W-1:0] L_BASE = ADDR_W'(BASE_ADDR);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [31:0]       r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [OCC_W-1:0]  r_occ;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_word_count;
  logic              r_err;
  logic [1:0]        r_err_code;

  logic              w_empty;
  logic              w_full;
  logic              w_in_ready;
  logic              w_accept;
  logic              w_push;
  logic              w_pop;
  logic              w_enter_load;
  logic [31:0]       w_enc;
  logic              w_bad_op;
  logic              w_bad_imm;
  logic              w_ovf;
  logic              w_err_any;
  logic [1:0]        w_code;
  logic [31:0]       w_total;
  logic signed [31:0] w_imm;

  assign w_imm = $signed(in_imm);

  always_comb begin
    w_enc     = '0;
    w_bad_op  = 1'b0;
    w_bad_imm = 1'b0;
    case (in_opcode)
      3'b000: begin
        w_enc     = {in_imm[11:0], in_rs1, 3'b010, in_rd, 7'b0000011};
        w_bad_imm = (w_imm < -2048) || (w_imm > 2047);
      end
      3'b001: begin
        w_enc     = {in_imm[11:5], in_rs2, in_rs1, 3'b010, in_imm[4:0], 7'b0100011};
        w_bad_imm = (w_imm < -2048) || (w_imm > 2047);
      end
      3'b010: w_enc = {7'b0000000, in_rs2, in_rs1, 3'b000, in_rd, 7'b0110011};
      3'b011: w_enc = {7'b0100000, in_rs2, in_rs1, 3'b000, in_rd, 7'b0110011};
      3'b100: w_enc = {7'b0000000, in_rs2, in_rs1, 3'b111, in_rd, 7'b0110011};
      3'b101: w_enc = {7'b0000000, in_rs2, in_rs1, 3'b110, in_rd, 7'b0110011};
      3'b110: begin
        w_enc     = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, 3'b000,
                     in_imm[4:1], in_imm[11], 7'b1100011};
        w_bad_imm = (w_imm < -4096) || (w_imm > 4094) || in_imm[0];
      end
      default: w_bad_op = 1'b1;
    endcase
  end

  // Words already written plus words still queued equals everything committed to this load.
  assign w_total    = 32'(r_word_count) + 32'(r_occ);
  assign w_ovf      = (w_total == 32'(MAX_WORDS));
  assign w_empty    = (r_occ == '0);
  assign w_full     = (r_occ == OCC_W'(FIFO_DEPTH));
  assign w_in_ready = (r_state == S_LOAD) && !w_full;
  assign w_accept   = in_valid && w_in_ready;
  assign w_err_any  = w_bad_op || w_bad_imm || w_ovf;
  assign w_push     = w_accept && !w_err_any;
  assign w_pop      = !w_empty && imem_ready;
  assign w_code     = w_bad_op ? 2'b01 : (w_bad_imm ? 2'b10 : 2'b11);
  assign w_enter_load = start && ((r_state == S_IDLE) || (r_state == S_DONE));

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_LOAD;
      S_LOAD:  if (w_accept && in_last) w_next = S_DRAIN;
      S_DRAIN: if (w_empty) w_next = S_DONE;
      S_DONE:  if (start) w_next = S_LOAD;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_occ        <= '0;
      r_addr       <= L_BASE;
      r_word_count <= '0;
      r_err        <= 1'b0;
      r_err_code   <= 2'b00;
    end else begin
      r_state <= w_next;
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      if (w_push && !w_pop)      r_occ <= r_occ + 1'b1;
      else if (!w_push && w_pop) r_occ <= r_occ - 1'b1;
      if (w_enter_load) begin
        r_addr       <= L_BASE;
        r_word_count <= '0;
        r_err        <= 1'b0;
        r_err_code   <= 2'b00;
      end else begin
        if (w_pop) begin
          r_addr       <= r_addr + ADDR_W'(4);
          r_word_count <= r_word_count + 1'b1;
        end
        if (w_accept && w_err_any && !r_err) begin
          r_err      <= 1'b1;
          r_err_code <= w_code;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= w_enc;
  end

  assign in_ready   = w_in_ready;
  assign imem_we    = !w_empty;
  assign imem_addr  = r_addr;
  assign imem_wdata = w_empty ? 32'd0 : r_mem[r_rptr];
  assign busy       = (r_state == S_LOAD) || (r_state == S_DRAIN);
  assign done       = (r_state == S_DONE);
  assign word_count = r_word_count;
  assign err        = r_err;
  assign err_code   = r_err_code;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb/tb_instr_encoder_loader.sv - bench for instr_encoder_loader with a behavioural write scoreboard
module tb_instr_encoder_loader;

  localparam int AW   = 12;
  localparam int MAXW = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [2:0]    in_opcode = '0;
  logic [4:0]    in_rs1 = '0;
  logic [4:0]    in_rs2 = '0;
  logic [4:0]    in_rd = '0;
  logic [31:0]   in_imm = '0;
  logic          in_last = 1'b0;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          imem_ready = 1'b1;
  logic          busy;
  logic          done;
  logic [AW-1:0] word_count;
  logic          err;
  logic [1:0]    err_code;

  instr_encoder_loader #(
    .ADDR_W(AW), .BASE_ADDR(0), .MAX_WORDS(MAXW), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_imm(in_imm), .in_last(in_last),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata), .imem_ready(imem_ready),
    .busy(busy), .done(done), .word_count(word_count), .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected writes, filled by the stimulus side and consumed by the compare process.
  logic [31:0] e_addr [256];
  logic [31:0] e_data [256];
  int n_push    = 0;
  int flush_idx = 0;
  int wc_base   = 0;
  int rd_idx    = 0;
  int wr_total  = 0;

  int   m_pushed = 0;
  logic m_err    = 1'b0;
  logic [1:0] m_code = 2'b00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] m_enc(input logic [31:0] op, input logic [31:0] rs1,
                                        input logic [31:0] rs2, input logic [31:0] rd,
                                        input logic [31:0] imm);
    logic [31:0] f3;
    logic [31:0] f7;
    case (op)
      0: return ((imm & 32'hFFF) << 20) | (rs1 << 15) | (32'h2 << 12) | (rd << 7) | 32'h03;
      1: return (((imm >> 5) & 32'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (32'h2 << 12)
                | ((imm & 32'h1F) << 7) | 32'h23;
      2, 3, 4, 5: begin
        f3 = (op == 4) ? 32'h7 : ((op == 5) ? 32'h6 : 32'h0);
        f7 = (op == 3) ? 32'h20 : 32'h0;
        return (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h33;
      end
      6: return (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25) | (rs2 << 20)
                | (rs1 << 15) | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 32'h1) << 7) | 32'h63;
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit m_imm_ok(input int op, input int imm);
    if (op == 0 || op == 1) return (imm >= -2048) && (imm <= 2047);
    if (op == 6) return (imm >= -4096) && (imm <= 4094) && (imm % 2 == 0);
    return 1'b1;
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      if (rd_idx < flush_idx) rd_idx = flush_idx;
      chk("word_count", 32'(word_count), 32'(wr_total - wc_base));
      if (imem_we && imem_ready) begin
        if (rd_idx >= n_push) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write: got addr 0x%03h data 0x%08h expected no write", imem_addr, imem_wdata);
        end else begin
          chk("write_addr", 32'(imem_addr), e_addr[rd_idx]);
          chk("write_data", imem_wdata, e_data[rd_idx]);
          rd_idx++;
        end
        wr_total++;
      end
    end
  end

  task automatic do_start();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    m_pushed = 0;
    m_err    = 1'b0;
    m_code   = 2'b00;
    wc_base  = wr_total;
  endtask

  task automatic send(input logic [2:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [4:0] rd, input int imm, input logic last);
    bit ok;
    logic [1:0] code;
    ok = 1'b0;
    in_valid = 1'b1; in_opcode = op; in_rs1 = rs1; in_rs2 = rs2;
    in_rd = rd; in_imm = imm; in_last = last;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    chk("accept_within_budget", 32'(ok), 32'd1);
    @(posedge clk);
    if (ok) begin
      if (op == 3'd7) code = 2'b01;
      else if (!m_imm_ok(int'(op), imm)) code = 2'b10;
      else if (m_pushed == MAXW) code = 2'b11;
      else code = 2'b00;
      if (code == 2'b00) begin
        e_addr[n_push] = 32'(4 * m_pushed);
        e_data[n_push] = m_enc(32'(op), 32'(rs1), 32'(rs2), 32'(rd), imm);
        n_push++;
        m_pushed++;
      end else if (!m_err) begin
        m_err  = 1'b1;
        m_code = code;
      end
    end
    #1 in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done) break;
    end
    chk({tag, " done"}, 32'(done), 32'd1);
    chk({tag, " busy"}, 32'(busy), 32'd0);
    chk({tag, " err"}, 32'(err), 32'(m_err));
    chk({tag, " err_code"}, 32'(err_code), 32'(m_code));
    chk({tag, " word_count"}, 32'(word_count), 32'(m_pushed));
    chk({tag, " pending"}, 32'(rd_idx), 32'(n_push));
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " in_ready"}, 32'(in_ready), 32'd0);
    chk({tag, " imem_we"}, 32'(imem_we), 32'd0);
    chk({tag, " imem_addr"}, 32'(imem_addr), 32'd0);
    chk({tag, " imem_wdata"}, imem_wdata, 32'd0);
    chk({tag, " busy"}, 32'(busy), 32'd0);
    chk({tag, " done"}, 32'(done), 32'd0);
    chk({tag, " word_count"}, 32'(word_count), 32'd0);
    chk({tag, " err"}, 32'(err), 32'd0);
    chk({tag, " err_code"}, 32'(err_code), 32'd0);
  endtask

  initial begin
    chk("model ADD", m_enc(2, 1, 2, 3, 0), 32'h002081B3);
    chk("model SUB", m_enc(3, 6, 7, 5, 0), 32'h407302B3);
    chk("model LW", m_enc(0, 2, 0, 4, 8), 32'h00812203);
    chk("model SW", m_enc(1, 1, 5, 0, 12), 32'h0050A623);
    chk("model BEQ", m_enc(6, 1, 2, 0, -8), 32'hFE208CE3);

    #3 chk_reset_vals("reset");
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // ADD then SUB(last)
    do_start();
    @(negedge clk);
    chk("load busy", 32'(busy), 32'd1);
    chk("load in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    send(3'd2, 5'd1, 5'd2, 5'd3, 0, 1'b0);
    send(3'd3, 5'd6, 5'd7, 5'd5, 0, 1'b1);
    wait_done("add_sub");
    chk("done in_ready", 32'(in_ready), 32'd0);

    // memory formats and immediate boundaries
    do_start();
    send(3'd0, 5'd2, 5'd0, 5'd4, 8, 1'b0);
    send(3'd1, 5'd1, 5'd5, 5'd0, 12, 1'b0);
    send(3'd6, 5'd1, 5'd2, 5'd0, -8, 1'b0);
    send(3'd6, 5'd3, 5'd4, 5'd0, 4094, 1'b0);
    send(3'd0, 5'd9, 5'd0, 5'd7, -2048, 1'b1);
    wait_done("formats");

    // write-side stall fills the FIFO
    imem_ready = 1'b0;
    do_start();
    send(3'd2, 5'd1, 5'd2, 5'd3, 0, 1'b0);
    send(3'd4, 5'd8, 5'd9, 5'd10, 0, 1'b0);
    send(3'd5, 5'd11, 5'd12, 5'd13, 0, 1'b0);
    send(3'd3, 5'd14, 5'd15, 5'd16, 0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall in_ready", 32'(in_ready), 32'd0);
      chk("stall imem_we", 32'(imem_we), 32'd1);
      chk("stall addr", 32'(imem_addr), 32'd0);
      chk("stall head", imem_wdata, 32'h002081B3);
    end
    @(posedge clk); #1 imem_ready = 1'b1;
    send(3'd5, 5'd31, 5'd30, 5'd29, 0, 1'b1);
    wait_done("stall");

    // errors: first code held, errored ops not written
    do_start();
    send(3'd7, 5'd1, 5'd2, 5'd3, 0, 1'b0);
    send(3'd0, 5'd1, 5'd0, 5'd3, 4096, 1'b0);
    send(3'd2, 5'd1, 5'd2, 5'd3, 0, 1'b0);
    send(3'd6, 5'd1, 5'd2, 5'd0, 3, 1'b0);
    send(3'd1, 5'd4, 5'd6, 5'd0, 2047, 1'b0);
    send(3'd6, 5'd5, 5'd6, 5'd0, -4096, 1'b1);
    wait_done("errors");
    chk("errors code", 32'(err_code), 32'd1);

    // capacity overflow
    do_start();
    for (int i = 0; i < MAXW + 1; i++)
      send(3'd2, 5'(i), 5'(i + 1), 5'(i + 2), 0, (i == MAXW) ? 1'b1 : 1'b0);
    wait_done("overflow");
    chk("overflow code", 32'(err_code), 32'd3);

    // reset while draining
    imem_ready = 1'b0;
    do_start();
    send(3'd2, 5'd1, 5'd2, 5'd3, 0, 1'b0);
    send(3'd4, 5'd4, 5'd5, 5'd6, 0, 1'b1);
    chk("drain busy", 32'(busy), 32'd1);
    chk("drain imem_we", 32'(imem_we), 32'd1);
    #2 reset = 1'b1;
    #1 chk_reset_vals("async reset");
    flush_idx = n_push;
    wc_base   = wr_total;
    m_pushed  = 0;
    m_err     = 1'b0;
    m_code    = 2'b00;
    imem_ready = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1;
    chk_reset_vals("post reset idle");

    do_start();
    send(3'd3, 5'd6, 5'd7, 5'd5, 0, 1'b1);
    wait_done("recover");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no completion expected finish before 200000");
    $fatal(1);
  end

endmodule
